// File: rtl/reset_request_initiator_pkg.sv
// Shared types and default constants for the reset request initiator.
package reset_request_initiator_pkg;

  typedef enum logic [1:0] {
    RRI_IDLE,
    RRI_ASSERT,
    RRI_RELEASE
  } rri_state_e;

  localparam int RRI_SYNC_DEPTH = 3;
  localparam int RRI_MIN_ASSERT = 16;
  localparam int RRI_TIMEOUT    = 1024;

endpackage

// File: rtl/reset_request_initiator_if.sv
// Handshake bundle between a reset requester, this initiator and the target domain.
// master: the initiator side. slave: requester / target side.
interface reset_request_initiator_if;
  logic reset_req;
  logic target_rst_ack;
  logic target_rst_req;
  logic busy;
  logic done;
  logic timeout;

  modport master (
    input  reset_req, target_rst_ack,
    output target_rst_req, busy, done, timeout
  );

  modport slave (
    output reset_req, target_rst_ack,
    input  target_rst_req, busy, done, timeout
  );
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_synchronizer #(
  parameter int DEPTH = 3
) (
  input  logic source_clk,
  input  logic source_rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  // Shift the asynchronous input through DEPTH flops.
  always_ff @(posedge source_clk or posedge source_rst) begin
    if (source_rst) sync_q <= '0;
    else            sync_q <= {sync_q[DEPTH-2:0], d};
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_request_initiator.sv
// Source-domain initiator of a four-phase reset handshake. Holds target_rst_req
// for at least MIN_ASSERT_CYCLES and until the synchronized ack arrives, then
// waits for the ack to drop. Each phase is bounded by TIMEOUT_CYCLES.
module reset_request_initiator
  import reset_request_initiator_pkg::*;
#(
  parameter int SYNC_DEPTH        = RRI_SYNC_DEPTH,
  parameter int MIN_ASSERT_CYCLES = RRI_MIN_ASSERT,
  parameter int TIMEOUT_CYCLES    = RRI_TIMEOUT
) (
  input logic                        source_clk,
  input logic                        source_rst,
  reset_request_initiator_if.master  rif
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] MIN_LAST = CNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

  if (SYNC_DEPTH < 2 || MIN_ASSERT_CYCLES < 1 || TIMEOUT_CYCLES <= MIN_ASSERT_CYCLES) begin : g_param_err
    $error("reset_request_initiator: illegal parameters SYNC_DEPTH=%0d MIN_ASSERT_CYCLES=%0d TIMEOUT_CYCLES=%0d",
           SYNC_DEPTH, MIN_ASSERT_CYCLES, TIMEOUT_CYCLES);
  end

  rri_state_e           state_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 req_q, busy_q, done_q, timeout_q;
  logic                 ack_s;

  bit_synchronizer #(.DEPTH(SYNC_DEPTH)) u_ack_sync (
    .source_clk (source_clk),
    .source_rst (source_rst),
    .d          (rif.target_rst_ack),
    .q          (ack_s)
  );

  // Phase counter increment, saturating so a stuck phase never wraps.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Handshake FSM with registered outputs; reset lands in ASSERT so power-on
  // drives a full sequence without any reset_req.
  always_ff @(posedge source_clk or posedge source_rst) begin
    if (source_rst) begin
      state_q   <= RRI_ASSERT;
      req_q     <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RRI_IDLE: begin
          if (rif.reset_req) begin
            state_q   <= RRI_ASSERT;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        RRI_ASSERT: begin
          // An ack on the final cycle still wins over the timeout.
          if (cnt_q >= MIN_LAST && ack_s) begin
            state_q <= RRI_RELEASE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q   <= RRI_RELEASE;
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RRI_RELEASE: begin
          if (!ack_s) begin
            state_q <= RRI_IDLE;
            busy_q  <= 1'b0;
            done_q  <= !timeout_q;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q   <= RRI_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= RRI_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rif.target_rst_req = req_q;
  assign rif.busy           = busy_q;
  assign rif.done           = done_q;
  assign rif.timeout        = timeout_q;

endmodule

// File: tb/tb_reset_request_initiator.sv
// Randomized bench for reset_request_initiator. The target is modelled as an
// ack that is a delayed copy of target_rst_req, or tied low/high; expected
// phase lengths come from the handshake timing rules.
module tb_reset_request_initiator;

  localparam int SYNC  = 3;
  localparam int MIN   = 16;
  localparam int TMO   = 64;
  localparam int GUARD = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // ack model: 0 = delayed copy of req by ack_d cycles, 1 = tied 0, 2 = tied 1
  int           ack_mode = 0;
  int           ack_d    = 2;
  logic [127:0] hist     = '0;

  reset_request_initiator_if rif();

  reset_request_initiator #(
    .SYNC_DEPTH        (SYNC),
    .MIN_ASSERT_CYCLES (MIN),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .source_clk (clk),
    .source_rst (rst),
    .rif        (rif.master)
  );

  always #5 clk = ~clk;

  // Target side: ack sampled at edge k equals req as it was after edge k-ack_d.
  always @(negedge clk) begin
    if (rst) hist = '0;
    else     hist = {hist[126:0], rif.target_rst_req};
    case (ack_mode)
      0:       rif.target_rst_ack = hist[ack_d-1];
      1:       rif.target_rst_ack = 1'b0;
      default: rif.target_rst_ack = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected req-high cycles, req-low busy cycles and outcome of one sequence.
  // extra = 1 when the sequence starts from source_rst (ack history restarts).
  function automatic void model(input int m, input int d, input int extra,
                                output int h, output int l, output bit dn, output bit to);
    case (m)
      0: begin
        h  = (d + SYNC + extra > MIN) ? d + SYNC + extra : MIN;
        l  = d + SYNC;
        dn = 1'b1;
        to = 1'b0;
      end
      1: begin h = TMO; l = 1;   dn = 1'b0; to = 1'b1; end
      default: begin h = MIN; l = TMO; dn = 1'b0; to = 1'b1; end
    endcase
  endfunction

  // One-cycle reset_req pulse from IDLE; returns on the first ASSERT negedge.
  task automatic start_seq();
    @(negedge clk);
    rif.reset_req = 1'b1;
    @(negedge clk);
    rif.reset_req = 1'b0;
    chk("accept_busy", rif.busy, 1);
    chk("accept_to_clr", rif.timeout, 0);
  endtask

  // Called on the first ASSERT negedge; measures the sequence against the model.
  task automatic seq_check(input int m, input int d, input int extra,
                           input bit hold_req, input int pulse_at);
    int eh, el, h, l, nd, guard;
    bit edn, eto;
    model(m, d, extra, eh, el, edn, eto);
    h = 0; l = 0; nd = 0; guard = 0;
    while (rif.target_rst_req === 1'b1 && guard < GUARD) begin
      if (rif.done) nd++;
      rif.reset_req = hold_req || (h == pulse_at);
      h++; guard++;
      @(negedge clk);
    end
    while (rif.busy === 1'b1 && guard < GUARD) begin
      if (rif.done) nd++;
      rif.reset_req = hold_req;
      l++; guard++;
      @(negedge clk);
    end
    chk("seq_bound", int'(guard < GUARD), 1);
    chk("hold_len", h, eh);
    chk("rel_len", l, el);
    chk("done_early", nd, 0);
    chk("done_end", rif.done, edn);
    chk("to_end", rif.timeout, eto);
    chk("idle_req", rif.target_rst_req, 0);
    if (!hold_req) begin
      @(negedge clk);
      chk("done_1cyc", rif.done, 0);
      chk("idle_busy", rif.busy, 0);
      chk("to_sticky", rif.timeout, eto);
    end
  endtask

  initial begin
    int r, m, d, p;
    rif.reset_req = 1'b0;

    // Reset state and power-on sequence
    ack_mode = 0; ack_d = 2;
    repeat (3) @(negedge clk);
    chk("rst_req", rif.target_rst_req, 1);
    chk("rst_busy", rif.busy, 1);
    chk("rst_done", rif.done, 0);
    chk("rst_to", rif.timeout, 0);
    @(negedge clk); #1 rst = 1'b0;
    seq_check(0, 2, 1, 1'b0, -1);

    // Slow ack
    ack_d = 40; repeat (60) @(negedge clk);
    start_seq(); seq_check(0, 40, 0, 1'b0, -1);

    // Assert-phase timeout
    ack_mode = 1; repeat (60) @(negedge clk);
    start_seq(); seq_check(1, 0, 0, 1'b0, -1);

    // Spurious ack in IDLE, then release-phase timeout
    ack_mode = 2;
    repeat (6) begin
      @(negedge clk);
      chk("spur_req", rif.target_rst_req, 0);
    end
    start_seq(); seq_check(2, 0, 0, 1'b0, -1);

    // Request mid-ASSERT is ignored and not queued
    ack_mode = 0; ack_d = 5; repeat (60) @(negedge clk);
    start_seq(); seq_check(0, 5, 0, 1'b0, 3);
    repeat (3) begin
      @(negedge clk);
      chk("no_queue", rif.busy, 0);
    end

    // Back-to-back with reset_req held high
    @(negedge clk); rif.reset_req = 1'b1;
    @(negedge clk);
    chk("b2b_first", rif.busy, 1);
    seq_check(0, 5, 0, 1'b1, -1);
    @(negedge clk);
    chk("b2b_busy", rif.busy, 1);
    chk("b2b_req", rif.target_rst_req, 1);
    chk("b2b_done", rif.done, 0);
    seq_check(0, 5, 0, 1'b1, -1);
    rif.reset_req = 1'b0;
    @(negedge clk);
    chk("b2b_stop", rif.busy, 0);
    chk("b2b_done_1", rif.done, 0);

    // Reset during RELEASE
    ack_d = 8; repeat (60) @(negedge clk);
    start_seq();
    for (int i = 0; i < 100 && rif.target_rst_req === 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("mid_in_rel", int'(rif.busy === 1'b1 && rif.target_rst_req === 1'b0), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_req", rif.target_rst_req, 1);
    chk("mid_busy", rif.busy, 1);
    chk("mid_done", rif.done, 0);
    repeat (3) @(negedge clk);
    @(negedge clk); #1 rst = 1'b0;
    seq_check(0, 8, 1, 1'b0, -1);

    // Randomized sequences
    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 5);
      m = (r < 4) ? 0 : r - 3;
      d = $urandom_range(1, 50);
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
      ack_mode = m; ack_d = d;
      repeat (60) @(negedge clk);
      start_seq();
      seq_check(m, d, 0, 1'b0, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
